instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the synchronous-read Memory block (16-bit words, 8-bit address).

---
 rtl/instruction_fetch.sv | 117 +++++++++++
 tb/tb_instruction_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a synchronous memory, holds the word in IR
// and hands it to decode over IR_Valid/IR_Ready. Supports PC redirect and HALT.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Mem_DOut              registered memory read data (valid the cycle after Address)
//   Mem_Address           memory address, always the PC register
//   Mem_Write_EN          active-low write enable, tied high (never writes)
//   PC_Load, PC_In        redirect strobe and target
//   IR_Ready              decode accepts IR this cycle
//   IR, IR_Valid, IR_PC   fetched word, valid flag, fetch address
//   Halted                HALT accepted, fetch stopped until redirect/reset

module instruction_fetch #(
  parameter int                       Data_WIDTH    = 16,
  parameter int                       Address_WIDTH = 8,
  parameter logic [Address_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter logic [3:0]               HALT_OPCODE   = 4'h1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [Data_WIDTH-1:0]    Mem_DOut,
  output logic [Address_WIDTH-1:0] Mem_Address,
  output logic                     Mem_Write_EN,
  input  logic                     PC_Load,
  input  logic [Address_WIDTH-1:0] PC_In,
  input  logic                     IR_Ready,
  output logic [Data_WIDTH-1:0]    IR,
  output logic                     IR_Valid,
  output logic [Address_WIDTH-1:0] IR_PC,
  output logic                     Halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_CAPTURE,
    S_VALID,
    S_HALT
  } state_t;

  state_t                   state, state_n;
  logic [Address_WIDTH-1:0] pc, pc_n;
  logic [Data_WIDTH-1:0]    ir_n;
  logic [Address_WIDTH-1:0] ir_pc_n;
  logic                     valid_n;
  logic                     halted_n;
  logic                     is_halt;

  assign Mem_Address  = pc;
  assign Mem_Write_EN = 1'b1;
  assign is_halt      = (IR[Data_WIDTH-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_FETCH;
      pc       <= RESET_VECTOR;
      IR       <= '0;
      IR_PC    <= RESET_VECTOR;
      IR_Valid <= 1'b0;
      Halted   <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      IR       <= ir_n;
      IR_PC    <= ir_pc_n;
      IR_Valid <= valid_n;
      Halted   <= halted_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = IR;
    ir_pc_n  = IR_PC;
    valid_n  = IR_Valid;
    halted_n = Halted;
    if (PC_Load) begin
      // Redirect drops whatever is in IR or in flight.
      pc_n     = PC_In;
      valid_n  = 1'b0;
      halted_n = 1'b0;
      state_n  = S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: begin
          state_n = S_CAPTURE;
        end
        S_CAPTURE: begin
          ir_n    = Mem_DOut;
          ir_pc_n = pc;
          pc_n    = pc + 1'b1;
          valid_n = 1'b1;
          state_n = S_VALID;
        end
        S_VALID: begin
          if (IR_Ready) begin
            valid_n = 1'b0;
            if (is_halt) begin
              halted_n = 1'b1;
              state_n  = S_HALT;
            end else begin
              state_n = S_FETCH;
            end
          end
        end
        S_HALT: begin
          state_n = S_HALT;
        end
        default: begin
          state_n = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, expected-word queue,
// directed steps covering fetch, stall, redirect, halt, wrap and reset.

module tb_instruction_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Mem_DOut;
  logic [7:0]  Mem_Address;
  logic        Mem_Write_EN;
  logic        PC_Load;
  logic [7:0]  PC_In;
  logic        IR_Ready;
  logic [15:0] IR;
  logic        IR_Valid;
  logic [7:0]  IR_PC;
  logic        Halted;

  instruction_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Mem_DOut     (Mem_DOut),
    .Mem_Address  (Mem_Address),
    .Mem_Write_EN (Mem_Write_EN),
    .PC_Load      (PC_Load),
    .PC_In        (PC_In),
    .IR_Ready     (IR_Ready),
    .IR           (IR),
    .IR_Valid     (IR_Valid),
    .IR_PC        (IR_PC),
    .Halted       (Halted)
  );

  always #5 Clk = ~Clk;

  logic [15:0] mem [0:255];

  always @(posedge Clk) Mem_DOut <= mem[Mem_Address];

  logic [23:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = -1;
  bit gap_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: score any handshake about to complete, then
  // advance to the next negedge.
  task automatic tick();
    logic [23:0] e;
    if (Mem_Write_EN !== 1'b1) chk("write_en", {31'd0, Mem_Write_EN}, 1);
    if (IR_Valid === 1'b1 && IR_Ready && !PC_Load && !Reset) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {8'd0, IR, IR_PC}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("ir", {16'd0, IR}, {16'd0, e[23:8]});
        chk("ir_pc", {24'd0, IR_PC}, {24'd0, e[7:0]});
      end
      if (gap_chk && last_acc >= 0) chk("gap", cyc - last_acc, 3);
      last_acc = cyc;
    end
    @(negedge Clk);
    cyc++;
  endtask

  task automatic push(input logic [7:0] a);
    sb.push_back({mem[a], a});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    assert (sb.size() == 0) else begin
      n_errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0",
             sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (IR_Valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'd0, IR_Valid}, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h9202;
    mem[8'h01] = 16'h9304;
    mem[8'h02] = 16'h2621;
    mem[8'h03] = 16'h1000;
    mem[8'h0A] = 16'h0666;
    mem[8'hFF] = 16'h4FF0;

    Reset    = 1'b1;
    PC_Load  = 1'b0;
    PC_In    = 8'h00;
    IR_Ready = 1'b0;
    @(negedge Clk);
    chk("rst_valid", {31'd0, IR_Valid}, 0);
    chk("rst_ir", {16'd0, IR}, 0);
    chk("rst_irpc", {24'd0, IR_PC}, 0);
    chk("rst_halted", {31'd0, Halted}, 0);
    chk("rst_addr", {24'd0, Mem_Address}, 0);
    chk("rst_wen", {31'd0, Mem_Write_EN}, 1);

    // Straight-line program, decode always ready.
    Reset    = 1'b0;
    IR_Ready = 1'b1;
    gap_chk  = 1;
    push(8'h00); push(8'h01); push(8'h02); push(8'h03);
    tick();
    chk("lat_c1", {31'd0, IR_Valid}, 0);
    tick();
    chk("lat_c2", {31'd0, IR_Valid}, 1);
    drain(40);
    gap_chk = 0;
    chk("halted", {31'd0, Halted}, 1);
    chk("halt_valid", {31'd0, IR_Valid}, 0);
    chk("halt_addr", {24'd0, Mem_Address}, 8'h04);

    // IR_Ready pulses while halted change nothing.
    for (int i = 0; i < 6; i++) begin
      IR_Ready = i[0];
      tick();
    end
    chk("halt_hold", {31'd0, Halted}, 1);
    chk("halt_hold_addr", {24'd0, Mem_Address}, 8'h04);
    chk("halt_hold_valid", {31'd0, IR_Valid}, 0);

    // Leave halt by redirect to 00.
    IR_Ready = 1'b0;
    PC_Load  = 1'b1;
    PC_In    = 8'h00;
    tick();
    PC_Load  = 1'b0;
    chk("unhalt", {31'd0, Halted}, 0);
    chk("unhalt_addr", {24'd0, Mem_Address}, 8'h00);
    IR_Ready = 1'b1;
    push(8'h00);
    drain(20);

    // Backpressure on 9304.
    IR_Ready = 1'b0;
    push(8'h01);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ir", {16'd0, IR}, 32'h9304);
      chk("stall_irpc", {24'd0, IR_PC}, 8'h01);
      chk("stall_valid", {31'd0, IR_Valid}, 1);
      chk("stall_addr", {24'd0, Mem_Address}, 8'h02);
    end
    IR_Ready = 1'b1;
    push(8'h02);
    drain(20);

    // Redirect while word 03 is in flight (now in S_FETCH at PC=03).
    tick();
    PC_Load = 1'b1;
    PC_In   = 8'h0A;
    tick();
    PC_Load = 1'b0;
    chk("redir_valid", {31'd0, IR_Valid}, 0);
    chk("redir_addr", {24'd0, Mem_Address}, 8'h0A);
    push(8'h0A);
    drain(20);

    // PC wrap FF -> 00.
    PC_Load = 1'b1;
    PC_In   = 8'hFF;
    tick();
    PC_Load = 1'b0;
    push(8'hFF);
    drain(20);
    chk("wrap_addr0", {24'd0, Mem_Address}, 8'h00);
    push(8'h00);
    drain(20);
    chk("wrap_addr1", {24'd0, Mem_Address}, 8'h01);

    // Reset while a word waits, with IR_Ready high on the same edge.
    IR_Ready = 1'b0;
    wait_valid(10);
    chk("pre_rst_irpc", {24'd0, IR_PC}, 8'h01);
    IR_Ready = 1'b1;
    Reset    = 1'b1;
    tick();
    Reset    = 1'b0;
    chk("mrst_valid", {31'd0, IR_Valid}, 0);
    chk("mrst_ir", {16'd0, IR}, 0);
    chk("mrst_addr", {24'd0, Mem_Address}, 0);
    chk("mrst_halted", {31'd0, Halted}, 0);
    push(8'h00);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
